calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 25 ++
 rtl/calc_operand_acc.sv | 29 ++
 rtl/calc_sequencer.sv | 126 ++++++++++++
 tb/tb_calc_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared key codes, ALU op encodings, FSM states and display selects
package calc_pkg;
    typedef enum logic [1:0] {ST_ENTER_A, ST_ENTER_B, ST_EXEC, ST_SHOW} state_t;
    localparam logic [4:0] KEY_ADD = 5'd10;
    localparam logic [4:0] KEY_SUB = 5'd11;
    localparam logic [4:0] KEY_MUL = 5'd12;
    localparam logic [4:0] KEY_AND = 5'd13;
    localparam logic [4:0] KEY_ORR = 5'd14;
    localparam logic [4:0] KEY_EQ  = 5'd15;
    localparam logic [4:0] KEY_CLR = 5'd16;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_ORR = 3'd4;
    localparam logic [1:0] SEL_A   = 2'd0;
    localparam logic [1:0] SEL_B   = 2'd1;
    localparam logic [1:0] SEL_RES = 2'd2;
    function automatic logic is_digit(logic [4:0] k);
        return k <= 5'd9;
    endfunction
    function automatic logic is_oper(logic [4:0] k);
        return k >= KEY_ADD && k <= KEY_ORR;
    endfunction
endpackage

// File: rtl/calc_operand_acc.sv
// calc_operand_acc: decimal digit accumulator (clk/rst_n, clr+load or push digit -> value, count)
module calc_operand_acc
    import calc_pkg::*;
#(
    parameter int DIGITS_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic        push,
    input  logic [3:0]  digit,
    output logic [15:0] value,
    output logic [7:0]  count
);
    localparam logic [7:0] MAXC = 8'(DIGITS_MAX);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            count <= '0;
        end else if (clr) begin
            value <= load ? {12'b0, digit} : '0;
            count <= load ? 8'd1 : '0;
        end else if (push && count < MAXC) begin
            value <= value * 16'd10 + {12'b0, digit};
            count <= count + 8'd1;
        end
    end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad calculator sequencer (click/key_code in, alu_req/op/a/b handshake with ack timeout, disp_value/flags/err/sel out)
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS_MAX  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        CLK_100MHZ,
    input  logic        reset,
    input  logic        click,
    input  logic [4:0]  key_code,
    output logic        alu_req,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_ack,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic [31:0] disp_value,
    output logic [3:0]  disp_flags,
    output logic        disp_err,
    output logic [1:0]  disp_sel
);
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
    state_t      state, state_nx;
    logic        click_q, ev, kc, kd, ko, ke, expire;
    logic [2:0]  op;
    logic [15:0] tmo, a_val, b_val;
    logic [7:0]  a_cnt, b_cnt;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        err;
    assign ev     = click & ~click_q;
    assign kc     = ev && key_code == KEY_CLR;
    assign kd     = ev && is_digit(key_code);
    assign ko     = ev && is_oper(key_code);
    assign ke     = ev && key_code == KEY_EQ;
    assign expire = state == ST_EXEC && tmo == TMO_LAST && !alu_ack;

    calc_operand_acc #(.DIGITS_MAX(DIGITS_MAX)) u_acc_a (
        .clk   (CLK_100MHZ),
        .rst_n (reset),
        .clr   (kc || (state == ST_SHOW && kd)),
        .load  (state == ST_SHOW && kd),
        .push  (state == ST_ENTER_A && kd),
        .digit (key_code[3:0]),
        .value (a_val),
        .count (a_cnt)
    );

    calc_operand_acc #(.DIGITS_MAX(DIGITS_MAX)) u_acc_b (
        .clk   (CLK_100MHZ),
        .rst_n (reset),
        .clr   (kc || (state == ST_SHOW && kd)),
        .load  (1'b0),
        .push  (state == ST_ENTER_B && kd),
        .digit (key_code[3:0]),
        .value (b_val),
        .count (b_cnt)
    );

    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) state <= ST_ENTER_A;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (kc) state_nx = ST_ENTER_A;
        else begin
            unique case (state)
                ST_ENTER_A: if (ko && a_cnt != '0) state_nx = ST_ENTER_B;
                ST_ENTER_B: if (ke && b_cnt != '0) state_nx = ST_EXEC;
                ST_EXEC:    if (alu_ack || expire) state_nx = ST_SHOW;
                ST_SHOW:    if (kd) state_nx = ST_ENTER_A;
                default:    state_nx = ST_ENTER_A;
            endcase
        end
    end

    always_comb begin
        alu_req    = state == ST_EXEC;
        alu_op     = op;
        alu_a      = a_val;
        alu_b      = b_val;
        disp_value = state == ST_ENTER_A ? {16'b0, a_val} : state == ST_SHOW ? res : {16'b0, b_val};
        disp_sel   = state == ST_ENTER_A ? SEL_A : state == ST_SHOW ? SEL_RES : SEL_B;
        disp_flags = flg;
        disp_err   = err;
    end

    // Counter only runs while in EXEC, so it is already zero on entry.
    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            click_q <= 1'b0;
            tmo     <= '0;
            op      <= OP_ADD;
        end else begin
            click_q <= click;
            tmo     <= state == ST_EXEC ? tmo + 16'd1 : '0;
            if (kc) op <= OP_ADD;
            else if (state == ST_ENTER_A && ko && a_cnt != '0) op <= 3'(key_code - KEY_ADD);
        end
    end

    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            res <= '0;
            flg <= '0;
            err <= 1'b0;
        end else if (kc) begin
            flg <= '0;
            err <= 1'b0;
        end else if (state == ST_EXEC && alu_ack) begin
            res <= alu_result;
            flg <= alu_flags;
            err <= 1'b0;
        end else if (expire) begin
            res <= '0;
            flg <= '0;
            err <= 1'b1;
        end else if (state == ST_SHOW && kd) begin
            err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and random checks of calc_sequencer against a behavioural model
module tb_calc_sequencer;
    localparam int DM = 4;
    localparam int TO = 255;
    localparam int MA = 0, MB = 1, MX = 2, MS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        click = 1'b0;
    logic [4:0]  key = 5'd31;
    logic        ack = 1'b0;
    logic [31:0] result = '0;
    logic [3:0]  flags = '0;
    logic        alu_req, disp_err;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic [31:0] disp_value;
    logic [3:0]  disp_flags;
    logic [1:0]  disp_sel;

    calc_sequencer #(.DIGITS_MAX(DM), .ACK_TIMEOUT(TO)) dut (
        .CLK_100MHZ (clk),
        .reset      (rst_n),
        .click      (click),
        .key_code   (key),
        .alu_req    (alu_req),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ack    (ack),
        .alu_result (result),
        .alu_flags  (flags),
        .disp_value (disp_value),
        .disp_flags (disp_flags),
        .disp_err   (disp_err),
        .disp_sel   (disp_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          m_st, m_a, m_b, m_na, m_nb, m_op, m_wait;
    logic [31:0] m_res;
    logic [3:0]  m_flg;
    bit          m_err, m_pclick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = MA; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_wait = 0;
        m_res = '0; m_flg = '0; m_err = 0; m_pclick = 0;
    endtask

    task automatic model_step(input bit c, input int k, input bit ak, input logic [31:0] r, input logic [3:0] f);
        bit ev;
        ev = c && !m_pclick;
        m_pclick = c;
        if (ev && k == 16) begin
            m_st = MA; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_err = 0; m_flg = '0;
        end else if (m_st == MA) begin
            if (ev && k <= 9 && m_na < DM) begin m_a = m_a * 10 + k; m_na++; end
            else if (ev && k >= 10 && k <= 14 && m_na > 0) begin m_op = k - 10; m_st = MB; end
        end else if (m_st == MB) begin
            if (ev && k <= 9 && m_nb < DM) begin m_b = m_b * 10 + k; m_nb++; end
            else if (ev && k == 15 && m_nb > 0) begin m_st = MX; m_wait = 0; end
        end else if (m_st == MX) begin
            if (ak) begin m_res = r; m_flg = f; m_err = 0; m_st = MS; end
            else if (m_wait == TO - 1) begin m_res = 0; m_flg = 0; m_err = 1; m_st = MS; end
            else m_wait++;
        end else if (ev && k <= 9) begin
            m_a = k; m_na = 1; m_b = 0; m_nb = 0; m_err = 0; m_st = MA;
        end
    endtask

    task automatic check_all();
        chk("alu_req", alu_req, m_st == MX);
        chk("alu_op", alu_op, m_op);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("disp_value", disp_value, m_st == MA ? m_a : m_st == MS ? m_res : m_b);
        chk("disp_flags", disp_flags, m_flg);
        chk("disp_err", disp_err, m_err);
        chk("disp_sel", disp_sel, m_st == MA ? 0 : m_st == MS ? 2 : 1);
    endtask

    task automatic cyc(input bit c, input int k, input bit ak = 0, input logic [31:0] r = 0, input logic [3:0] f = 0);
        click = c; key = 5'(k); ack = ak; result = r; flags = f;
        model_step(c, k, ak, r, f);
        @(negedge clk);
        check_all();
    endtask

    task automatic press(input int k);
        cyc(1, k);
        cyc(0, k);
    endtask

    initial begin
        int n, r, k;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        press(1); press(2); press(10); press(3); press(4); press(15);
        chk("basic_req", alu_req, 1);
        chk("basic_op", alu_op, 0);
        chk("basic_a", alu_a, 12);
        chk("basic_b", alu_b, 34);
        cyc(0, 31, 1, 46, 4'b0000);
        chk("basic_req_drop", alu_req, 0);
        chk("basic_result", disp_value, 46);
        chk("basic_sel", disp_sel, 2);

        press(12); press(15);
        chk("show_oper_ignored", disp_value, 46);
        press(4);
        chk("show_digit_value", disp_value, 4);
        chk("show_digit_sel", disp_sel, 0);
        chk("show_digit_err", disp_err, 0);

        press(16);
        press(9); press(8); press(7); press(6); press(5);
        chk("digit_limit", disp_value, 9876);

        press(16);
        repeat (100) cyc(1, 3);
        cyc(0, 3);
        chk("held_click", disp_value, 3);

        press(16); press(10); press(15);
        chk("plus_no_a_sel", disp_sel, 0);
        press(7); press(11); press(15);
        chk("eq_no_b_req", alu_req, 0);
        chk("eq_no_b_sel", disp_sel, 1);

        press(16); press(5); press(12); press(7);
        cyc(1, 15);
        n = 1;
        while (alu_req === 1'b1 && n < 400) begin
            cyc(0, 31);
            if (alu_req === 1'b1) n++;
        end
        chk("timeout_len", n, TO);
        chk("timeout_err", disp_err, 1);
        chk("timeout_value", disp_value, 0);

        press(16); press(5); press(12); press(7);
        cyc(1, 15);
        repeat (TO - 1) cyc(0, 31);
        chk("ack_last_req", alu_req, 1);
        cyc(0, 31, 1, 35, 4'b0010);
        chk("ack_last_value", disp_value, 35);
        chk("ack_last_err", disp_err, 0);

        press(16); press(1); press(13); press(2); press(15);
        cyc(1, 16);
        chk("clr_exec_req", alu_req, 0);
        chk("clr_exec_value", disp_value, 0);
        chk("clr_exec_sel", disp_sel, 0);

        cyc(0, 16);
        press(6); press(14); press(8); press(15);
        #2 rst_n = 1'b0;
        #1 chk("async_req", alu_req, 0);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 31, 1, 99, 4'b1111);
        chk("late_ack_value", disp_value, 0);
        chk("late_ack_sel", disp_sel, 0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 39);
            k = r < 20 ? r % 10 : r < 28 ? 10 + r % 5 : r < 34 ? 15 : r < 35 ? 16 : 17 + r % 15;
            cyc($urandom_range(0, 2) == 0, k, $urandom_range(0, 7) == 0, $urandom, 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
